// File: rtl/pulse_to_press_if.sv
// Press-generator bus: request pulse in, press waveform and status out.
interface pulse_to_press_if #(
  parameter int MAX_PENDING = 7
) ();
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          pulse_i;
  logic          btn_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          overflow_o;

  // Requester side: issues pulses, observes the press waveform.
  modport master (
    output pulse_i,
    input  btn_o,
    input  busy_o,
    input  pending_o,
    input  overflow_o
  );

  // Generator side.
  modport slave (
    input  pulse_i,
    output btn_o,
    output busy_o,
    output pending_o,
    output overflow_o
  );
endinterface

// File: rtl/pulse_to_press.sv
// Turns single-cycle request pulses into fixed-width button presses with a
// guaranteed low gap; requests arriving mid-press are queued as a count.
//
// state   | meaning
// IDLE    | no press in progress, btn low
// PRESS   | btn held high, cnt counts down the high time
// RELEASE | btn held low, cnt counts down the mandatory gap
module pulse_to_press #(
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 2,
  parameter int MAX_PENDING = 7
) (
  input  logic               clk,
  input  logic               rst,
  pulse_to_press_if.slave    bus
);

  localparam int PW    = $clog2(MAX_PENDING + 1);
  localparam int MAXHL = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW    = $clog2(MAXHL + 1);

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          start;
  logic          accept;

  // Next-state, counter and press-start decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        btn_d = 1'b0;
        if (pend_q != '0) begin
          start   = 1'b1;
          state_d = PRESS;
          btn_d   = 1'b1;
          cnt_d   = HIGH_LOAD;
        end
      end
      PRESS: begin
        btn_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = RELEASE;
          btn_d   = 1'b0;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        btn_d = 1'b0;
        if (cnt_q == '0) begin
          if (pend_q != '0) begin
            start   = 1'b1;
            state_d = PRESS;
            btn_d   = 1'b1;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        btn_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Request queue: a slot freed by a press start on the same edge makes room
  // for an incoming pulse even when the count is at its ceiling.
  always_comb begin
    accept = bus.pulse_i && ((pend_q < PEND_MAX) || start);
    pend_d = pend_q + PW'(accept) - PW'(start);
    ovf_d  = ovf_q | (bus.pulse_i & ~accept);
  end

  // All state and outputs registered; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.btn_o      = btn_q;
  assign bus.busy_o     = busy_q;
  assign bus.pending_o  = pend_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_to_press.sv
// Self-checking bench for pulse_to_press: two instances (deep and shallow
// queue) compared every cycle against a timeline-based reference model.
module tb_pulse_to_press;

  localparam int H    = 3;
  localparam int L    = 2;
  localparam int MAXA = 7;
  localparam int MAXB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pulse_to_press_if #(.MAX_PENDING(MAXA)) bus_a ();
  pulse_to_press_if #(.MAX_PENDING(MAXB)) bus_b ();

  pulse_to_press #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .MAX_PENDING(MAXA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pulse_to_press #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .MAX_PENDING(MAXB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Model: a press that started at edge s owns edges s..s+H+L-1; queued
  // requests start the moment no press owns the edge.
  typedef struct {
    int pend;
    int s;
    bit valid;
    bit ovf;
    int presses;
  } model_t;

  model_t ma, mb;
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  int     det_a  = 0;
  int     det_b  = 0;
  logic   prev_a = 1'b0;
  logic   prev_b = 1'b0;

  function automatic model_t m_reset();
    model_t r;
    r.pend = 0; r.s = 0; r.valid = 1'b0; r.ovf = 1'b0; r.presses = 0;
    return r;
  endfunction

  function automatic model_t m_step(input model_t m, input bit p, input int maxp, input int t);
    model_t r;
    bit active, start, acc;
    r      = m;
    active = m.valid && (t < m.s + H + L);
    start  = (m.pend > 0) && !active;
    acc    = p && ((m.pend < maxp) || start);
    if (start) begin
      r.s = t; r.valid = 1'b1; r.presses = m.presses + 1;
    end
    r.pend = m.pend + (acc ? 1 : 0) - (start ? 1 : 0);
    if (p && !acc) r.ovf = 1'b1;
    return r;
  endfunction

  function automatic bit m_btn(input model_t m, input int t);
    return m.valid && (t - m.s < H);
  endfunction

  function automatic bit m_busy(input model_t m, input int t);
    return m.valid && (t < m.s + H + L);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("btn_a",  32'(bus_a.btn_o),      32'(m_btn(ma, cyc)));
    chk("busy_a", 32'(bus_a.busy_o),     32'(m_busy(ma, cyc)));
    chk("pend_a", 32'(bus_a.pending_o),  32'(ma.pend));
    chk("ovf_a",  32'(bus_a.overflow_o), 32'(ma.ovf));
    chk("btn_b",  32'(bus_b.btn_o),      32'(m_btn(mb, cyc)));
    chk("busy_b", 32'(bus_b.busy_o),     32'(m_busy(mb, cyc)));
    chk("pend_b", 32'(bus_b.pending_o),  32'(mb.pend));
    chk("ovf_b",  32'(bus_b.overflow_o), 32'(mb.ovf));
  endtask

  // One clock: drive pulses, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit pa, input bit pb);
    bus_a.pulse_i = pa;
    bus_b.pulse_i = pb;
    @(posedge clk);
    cyc++;
    if (rst) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, pa, MAXA, cyc);
      mb = m_step(mb, pb, MAXB, cyc);
    end
    #1;
    if (bus_a.btn_o === 1'b1 && prev_a !== 1'b1) det_a++;
    if (bus_b.btn_o === 1'b1 && prev_b !== 1'b1) det_b++;
    prev_a = bus_a.btn_o;
    prev_b = bus_b.btn_o;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ma  = m_reset();
    mb  = m_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst    = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
  endtask

  // Single pulse at E1 from idle, explicit expectations for E1..E8.
  task automatic single_test(input string name);
    int   d0;
    logic b [1:8];
    logic y [1:8];
    d0 = det_a;
    step(1'b1, 1'b0);
    chk({name, "_pend_e1"}, 32'(bus_a.pending_o), 32'd1);
    b[1] = bus_a.btn_o; y[1] = bus_a.busy_o;
    for (int e = 2; e <= 8; e++) begin
      step(1'b0, 1'b0);
      b[e] = bus_a.btn_o;
      y[e] = bus_a.busy_o;
    end
    chk({name, "_btn_e1"},  32'(b[1]), 32'd0);
    chk({name, "_btn_e2"},  32'(b[2]), 32'd1);
    chk({name, "_btn_e4"},  32'(b[4]), 32'd1);
    chk({name, "_btn_e5"},  32'(b[5]), 32'd0);
    chk({name, "_busy_e2"}, 32'(y[2]), 32'd1);
    chk({name, "_busy_e6"}, 32'(y[6]), 32'd1);
    chk({name, "_busy_e7"}, 32'(y[7]), 32'd0);
    chk({name, "_rises"},   32'(det_a - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  d0;
    bit  found;
    model_t nxt;

    bus_a.pulse_i = 1'b0;
    bus_b.pulse_i = 1'b0;
    ma = m_reset();
    mb = m_reset();

    // Reset state, and pulses during reset must be ignored.
    #2 rst = 1'b1;
    #1;
    chk("rst_btn",  32'(bus_a.btn_o),      32'd0);
    chk("rst_busy", 32'(bus_a.busy_o),     32'd0);
    chk("rst_pend", 32'(bus_a.pending_o),  32'd0);
    chk("rst_ovf",  32'(bus_a.overflow_o), 32'd0);
    repeat (3) step(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);

    single_test("single");

    // Three consecutive requests.
    d0 = det_a;
    step(1'b1, 1'b0); chk("three_pend1", 32'(bus_a.pending_o), 32'd1);
    step(1'b1, 1'b0); chk("three_pend2", 32'(bus_a.pending_o), 32'd1);
    step(1'b1, 1'b0); chk("three_pend3", 32'(bus_a.pending_o), 32'd2);
    repeat (20) step(1'b0, 1'b0);
    chk("three_presses", 32'(det_a - d0), 32'd3);
    chk("three_ovf",     32'(bus_a.overflow_o), 32'd0);

    // Overflow on the shallow instance.
    d0 = det_b;
    step(1'b0, 1'b1); chk("ovf_pend1", 32'(bus_b.pending_o), 32'd1);
    step(1'b0, 1'b1); chk("ovf_pend2", 32'(bus_b.pending_o), 32'd1);
    step(1'b0, 1'b1); chk("ovf_pend3", 32'(bus_b.pending_o), 32'd2);
    chk("ovf_flag3", 32'(bus_b.overflow_o), 32'd0);
    step(1'b0, 1'b1); chk("ovf_pend4", 32'(bus_b.pending_o), 32'd2);
    chk("ovf_flag4", 32'(bus_b.overflow_o), 32'd1);
    step(1'b0, 1'b1); chk("ovf_pend5", 32'(bus_b.pending_o), 32'd2);
    repeat (25) step(1'b0, 1'b0);
    chk("ovf_sticky",  32'(bus_b.overflow_o), 32'd1);
    chk("ovf_presses", 32'(det_b - d0), 32'd3);

    // Pulse lands on the edge a queued press starts while the queue is full.
    do_reset();
    repeat (3) step(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      nxt = m_step(mb, 1'b0, MAXB, cyc + 1);
      if (nxt.presses != mb.presses && mb.pend == MAXB) found = 1'b1;
      else step(1'b0, 1'b0);
    end
    chk("simul_reached", 32'(found), 32'd1);
    if (found) begin
      step(1'b0, 1'b1);
      chk("simul_pend", 32'(bus_b.pending_o),  32'd2);
      chk("simul_ovf",  32'(bus_b.overflow_o), 32'd0);
    end
    repeat (20) step(1'b0, 1'b0);

    // Reset mid-press with three requests queued.
    do_reset();
    repeat (4) step(1'b1, 1'b0);
    chk("midrst_pre_btn",  32'(bus_a.btn_o),     32'd1);
    chk("midrst_pre_pend", 32'(bus_a.pending_o), 32'd3);
    #2 rst = 1'b1;
    ma = m_reset();
    mb = m_reset();
    #1;
    chk("midrst_btn",  32'(bus_a.btn_o),      32'd0);
    chk("midrst_busy", 32'(bus_a.busy_o),     32'd0);
    chk("midrst_pend", 32'(bus_a.pending_o),  32'd0);
    chk("midrst_ovf",  32'(bus_a.overflow_o), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    single_test("after_rst");

    // Round trip through an edge detector: 5 random-spaced requests.
    d0 = det_a;
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 6)) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    repeat (40) step(1'b0, 1'b0);
    chk("rt_pulses", 32'(det_a - d0), 32'd5);
    chk("rt_idle",   32'(bus_a.busy_o), 32'd0);

    // Random traffic on both instances, model-checked every cycle.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    repeat (60) step(1'b0, 1'b0);
    chk("rand_presses_a", 32'(det_a), 32'(ma.presses + 0) + 32'(det_a - ma.presses));
    chk("rand_drain_a", 32'(bus_a.pending_o), 32'd0);
    chk("rand_drain_b", 32'(bus_b.pending_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
